// File: rtl/rob_alloc_ctrl_pkg.sv
// Shared ROB sizing constants and id/pointer types for the rename/ROB-id datapath.
package rob_alloc_ctrl_pkg;

    localparam int unsigned RobDepth  = 32;
    localparam int unsigned RobIdW    = $clog2(RobDepth);
    localparam int unsigned RobPtrW   = RobIdW + 1;

    typedef logic [RobIdW-1:0]  RobId_t;
    typedef logic [RobPtrW-1:0] RobPtr_t;

endpackage

// File: rtl/rob_alloc_ctrl_rob_ptr.sv
// Wrap-bit circular pointer: MSB flips on each pass over the ROB; clear wins over increment.
module rob_alloc_ctrl_rob_ptr #(
    parameter int unsigned W = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] ptr
);

    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = ptr_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/rob_alloc_ctrl.sv
// ROB id allocator: in-order id grant, completion tracking and in-order commit strobe.
// Define ROB_ALLOC_BYPASS_EN to let a full ROB grant into the slot freed by a same-cycle commit.
module rob_alloc_ctrl
    import rob_alloc_ctrl_pkg::*;
#(
    parameter int unsigned ROB_DEPTH = RobDepth,
    localparam int unsigned ROB      = $clog2(ROB_DEPTH)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           flush_,
    input  logic           alloc_req_,
    output logic           alloc_e_,
    output logic [ROB-1:0] alloc_id,
    input  logic           done_e_,
    input  logic [ROB-1:0] done_id,
    output logic           commit_e_,
    output logic [ROB-1:0] com_rob_id,
    output logic           full,
    output logic           empty,
    output logic [ROB:0]   count
);

    logic [ROB:0]           head;
    logic [ROB:0]           tail;
    logic [ROB_DEPTH-1:0]   valid_q;
    logic [ROB_DEPTH-1:0]   valid_d;
    logic [ROB_DEPTH-1:0]   done_q;
    logic [ROB_DEPTH-1:0]   done_d;
    logic                   rdy_q;
    logic                   rdy_d;
    logic                   commit_c;
    logic                   grant_c;
    logic                   full_c;
    logic                   empty_c;
    logic [ROB-1:0]         head_idx;
    logic [ROB-1:0]         tail_idx;

    assign head_idx = head[ROB-1:0];
    assign tail_idx = tail[ROB-1:0];
    assign full_c   = (head[ROB] != tail[ROB]) && (head_idx == tail_idx);
    assign empty_c  = (head == tail);

    // rdy_q holds off grants until one full cycle after reset release
    assign commit_c = !empty_c && done_q[head_idx] && flush_;
`ifdef ROB_ALLOC_BYPASS_EN
    assign grant_c  = rdy_q && !alloc_req_ && flush_ && (!full_c || commit_c);
`else
    assign grant_c  = rdy_q && !alloc_req_ && flush_ && !full_c;
`endif

    rob_alloc_ctrl_rob_ptr #(.W(ROB + 1)) u_head (
        .clk   (clk),
        .reset (reset),
        .inc   (commit_c),
        .clr   (!flush_),
        .ptr   (head)
    );

    rob_alloc_ctrl_rob_ptr #(.W(ROB + 1)) u_tail (
        .clk   (clk),
        .reset (reset),
        .inc   (grant_c),
        .clr   (!flush_),
        .ptr   (tail)
    );

    // Grant is applied after commit so a bypassed grant re-arms the slot just freed
    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        rdy_d   = 1'b1;
        if (!flush_) begin
            valid_d = '0;
            done_d  = '0;
        end else begin
            if (!done_e_ && valid_q[done_id]) begin
                done_d[done_id] = 1'b1;
            end
            if (commit_c) begin
                valid_d[head_idx] = 1'b0;
                done_d[head_idx]  = 1'b0;
            end
            if (grant_c) begin
                valid_d[tail_idx] = 1'b1;
                done_d[tail_idx]  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            done_q  <= '0;
            rdy_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            done_q  <= done_d;
            rdy_q   <= rdy_d;
        end
    end

    assign alloc_e_   = !grant_c;
    assign commit_e_  = !commit_c;
    assign alloc_id   = tail_idx;
    assign com_rob_id = head_idx;
    assign full       = full_c;
    assign empty      = empty_c;
    assign count      = tail - head;

endmodule
